hyperbus_burst_ctrl: RTL and testbench

Burst sequencer that sits directly upstream of the HyperBus leader controller. It accepts length-tagged read and write commands and drives the controller's `rrq`/`wrq`/`adr_i`/`dat_i`/`mask_i` request interface. It counts returned `valid` words so that `rrq` drops after exactly the requested burst, and stages data through one shared word FIFO: read data is buffered because the controller cannot be stalled, and write data is preloaded so that `dat_i` is never starved while `ready` is high.

---
 rtl/hyperbus_burst_ctrl_if.sv | 67 ++++++
 rtl/hyperbus_burst_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hyperbus_burst_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_burst_ctrl_if.sv
// Command, data and controller-facing signal bundle for the HyperBus burst sequencer.
// The slave modport is the sequencer itself; master is the user and controller side.
interface hyperbus_burst_ctrl_if #(
  parameter int WIDTH       = 8,
  parameter int ADDR_LENGTH = 32,
  parameter int LEN_WIDTH   = 8
);
  localparam int DW = 2 * WIDTH;
  localparam int MW = (2 * WIDTH) / 8 + 1;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_we;
  logic                   cmd_reg;
  logic [ADDR_LENGTH-1:0] cmd_adr;
  logic [LEN_WIDTH-1:0]   cmd_len;

  logic                   wdat_valid;
  logic                   wdat_ready;
  logic [DW-1:0]          wdat;
  logic [1:0]             wmask;

  logic                   rdat_valid;
  logic                   rdat_ready;
  logic [DW-1:0]          rdat;
  logic                   rdat_last;

  logic [ADDR_LENGTH-1:0] hb_adr;
  logic                   hb_reg;
  logic [DW-1:0]          hb_dat_o;
  logic [MW-1:0]          hb_mask;
  logic [DW-1:0]          hb_dat_i;
  logic                   hb_valid;
  logic                   hb_ready;
  logic                   hb_rrq;
  logic                   hb_wrq;

  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output cmd_valid, cmd_we, cmd_reg, cmd_adr, cmd_len,
    input  cmd_ready,
    output wdat_valid, wdat, wmask,
    input  wdat_ready,
    input  rdat_valid, rdat, rdat_last,
    output rdat_ready,
    input  hb_adr, hb_reg, hb_dat_o, hb_mask,
    output hb_dat_i, hb_valid, hb_ready,
    input  hb_rrq, hb_wrq,
    input  busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_reg, cmd_adr, cmd_len,
    output cmd_ready,
    input  wdat_valid, wdat, wmask,
    output wdat_ready,
    output rdat_valid, rdat, rdat_last,
    input  rdat_ready,
    output hb_adr, hb_reg, hb_dat_o, hb_mask,
    input  hb_dat_i, hb_valid, hb_ready,
    output hb_rrq, hb_wrq,
    output busy, done, err
  );
endinterface

// File: rtl/hyperbus_burst_ctrl.sv
// Burst sequencer in front of the HyperBus leader controller: counts words,
// stages read and write data through one shared FIFO, times out stalled reads.
module hyperbus_burst_ctrl #(
  parameter int WIDTH       = 8,
  parameter int ADDR_LENGTH = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT     = 64
) (
  input logic clk90,
  input logic rst,
  hyperbus_burst_ctrl_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int MW = DW / 8 + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DW + 3;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WRITE,
    READ,
    GAP
  } state_t;

  state_t                 state;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          wp;
  logic [PW-1:0]          rp;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   wcnt;
  logic [TW-1:0]          icnt;
  logic                   gcnt;
  logic                   live;
  logic [ADDR_LENGTH-1:0] adr_q;
  logic                   reg_q;
  logic                   rrq;
  logic                   wrq;
  logic                   done_q;
  logic                   err_q;

  logic                   empty;
  logic                   full;
  logic                   in_wr;
  logic                   accept;
  logic                   too_long;
  logic                   last_w;
  logic                   push_w;
  logic                   push_r;
  logic                   pop_w;
  logic                   pop_r;
  logic                   push;
  logic                   pop;
  logic                   timeout;
  logic                   rvalid;
  logic [LEN_WIDTH:0]     len_p1;
  logic [EW-1:0]          head;
  logic [EW-1:0]          din;

  always_comb begin
    empty    = wp == rp;
    full     = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    head     = mem[rp[AW-1:0]];
    in_wr    = state == WFILL || state == WRITE;
    rvalid   = !empty && !in_wr;
    accept   = bus.cmd_valid && bus.cmd_ready;
    len_p1   = {1'b0, bus.cmd_len} + (LEN_WIDTH+1)'(1);
    too_long = len_p1 > (LEN_WIDTH+1)'(FIFO_DEPTH);
    last_w   = wcnt == len;
    push_w   = state == WFILL && bus.wdat_valid;
    push_r   = state == READ && bus.hb_valid && !full;
    pop_w    = state == WRITE && bus.hb_ready && wrq;
    pop_r    = rvalid && bus.rdat_ready;
    timeout  = state == READ && !bus.hb_valid
               && icnt == TW'(TIMEOUT - 1);
    push     = push_w || push_r;
    pop      = pop_w || pop_r;
    din      = {push_r && last_w, 2'b00, bus.hb_dat_i};
    if (push_w) din = {1'b0, bus.wmask, bus.wdat};
  end

  assign bus.cmd_ready  = live && state == IDLE && empty;
  assign bus.wdat_ready = state == WFILL;
  assign bus.rdat_valid = rvalid;
  assign bus.rdat       = head[DW-1:0];
  assign bus.rdat_last  = rvalid && head[EW-1];
  assign bus.hb_adr     = adr_q;
  assign bus.hb_reg     = reg_q;
  assign bus.hb_dat_o   = head[DW-1:0];
  assign bus.hb_mask    = MW'(head[DW+1:DW]);
  assign bus.hb_rrq     = rrq;
  assign bus.hb_wrq     = wrq;
  assign bus.busy       = state != IDLE;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  // storage carries no reset; occupancy is defined purely by the pointers
  always_ff @(posedge clk90) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (timeout) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
    end
  end

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      live   <= 1'b0;
      len    <= '0;
      wcnt   <= '0;
      icnt   <= '0;
      gcnt   <= 1'b0;
      adr_q  <= '0;
      reg_q  <= 1'b0;
      rrq    <= 1'b0;
      wrq    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      live   <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            adr_q <= bus.cmd_adr;
            reg_q <= bus.cmd_reg;
            len   <= bus.cmd_len;
            wcnt  <= '0;
            icnt  <= '0;
            if (too_long) begin
              err_q <= 1'b1;
            end else if (bus.cmd_we) begin
              state <= WFILL;
            end else begin
              rrq   <= 1'b1;
              state <= READ;
            end
          end
        end
        WFILL: begin
          if (push_w) begin
            if (last_w) begin
              wcnt  <= '0;
              wrq   <= 1'b1;
              state <= WRITE;
            end else begin
              wcnt <= wcnt + LEN_WIDTH'(1);
            end
          end
        end
        WRITE: begin
          if (pop_w) begin
            wcnt <= wcnt + LEN_WIDTH'(1);
            if (last_w) begin
              wrq    <= 1'b0;
              done_q <= 1'b1;
              gcnt   <= 1'b0;
              state  <= GAP;
            end
          end
        end
        READ: begin
          if (timeout) begin
            rrq   <= 1'b0;
            err_q <= 1'b1;
            gcnt  <= 1'b0;
            state <= GAP;
          end else if (bus.hb_valid) begin
            icnt <= '0;
            if (push_r) begin
              wcnt <= wcnt + LEN_WIDTH'(1);
              if (last_w) begin
                rrq    <= 1'b0;
                done_q <= 1'b1;
                gcnt   <= 1'b0;
                state  <= GAP;
              end
            end
          end else begin
            icnt <= icnt + TW'(1);
          end
        end
        GAP: begin
          // two cycles with both requests low so the controller idles
          if (gcnt) state <= IDLE;
          else      gcnt  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Randomized bench for hyperbus_burst_ctrl: queue-based model of burst
// contents, framing and timing rules, one task per scenario.
module tb_hyperbus_burst_ctrl;
  logic clk90 = 1'b0;
  logic rst   = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk90 = ~clk90;

  hyperbus_burst_ctrl_if #(.WIDTH(8), .ADDR_LENGTH(32), .LEN_WIDTH(8)) bus ();

  hyperbus_burst_ctrl #(
    .WIDTH(8), .ADDR_LENGTH(32), .LEN_WIDTH(8),
    .FIFO_DEPTH(8), .TIMEOUT(64)
  ) dut (
    .clk90(clk90),
    .rst(rst),
    .bus(bus)
  );

  task automatic init_inputs;
    bus.cmd_valid  = 0;
    bus.cmd_we     = 0;
    bus.cmd_reg    = 0;
    bus.cmd_adr    = '0;
    bus.cmd_len    = '0;
    bus.wdat_valid = 0;
    bus.wdat       = '0;
    bus.wmask      = '0;
    bus.rdat_ready = 0;
    bus.hb_dat_i   = '0;
    bus.hb_valid   = 0;
    bus.hb_ready   = 0;
  endtask

  task automatic issue(input bit we, input int len, input logic [31:0] adr);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk90);
      n++;
    end
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready_wait got %b want 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1;
    bus.cmd_we    = we;
    bus.cmd_len   = 8'(len);
    bus.cmd_adr   = adr;
    bus.cmd_reg   = 1'($urandom_range(0, 1));
    @(negedge clk90);
    bus.cmd_valid = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk90);
    total++;
    if ({bus.cmd_ready, bus.hb_rrq, bus.hb_wrq, bus.busy, bus.done,
         bus.err, bus.rdat_valid, bus.rdat_last, bus.wdat_ready} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got %b want 0", {bus.cmd_ready,
        bus.hb_rrq, bus.hb_wrq, bus.busy, bus.done, bus.err,
        bus.rdat_valid, bus.rdat_last, bus.wdat_ready});
    end
    total++;
    if (bus.hb_adr !== 32'h0) begin
      bad++;
      $display("FAIL reset_adr got %h want 0", bus.hb_adr);
    end
    rst = 0;
    @(negedge clk90);
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_read;
    logic [15:0] w[4];
    logic [15:0] got[$];
    logic [31:0] adr;
    int lastpos, rcnt, dcnt, gap;
    bit seen;
    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    lastpos = -1; dcnt = 0; gap = 0; seen = 0;
    adr = $urandom;
    issue(0, 3, adr);
    rcnt = int'(bus.hb_rrq);
    bus.rdat_ready = 1;
    for (int i = 0; i < 8; i++) begin
      bus.hb_valid = i < 5;
      bus.hb_dat_i = (i < 4) ? w[i % 4] : 16'hdead;
      @(negedge clk90);
      if (bus.hb_rrq) rcnt++;
      if (bus.done) begin
        dcnt++;
        seen = 1;
      end
      if (seen && bus.busy) gap++;
      if (bus.rdat_valid) begin
        if (bus.rdat_last) lastpos = got.size();
        got.push_back(bus.rdat);
      end
    end
    bus.hb_valid = 0;
    bus.rdat_ready = 0;
    total++;
    if (rcnt != 4) begin
      bad++;
      $display("FAIL read_rrq_cycles got %0d want 4", rcnt);
    end
    total++;
    if (dcnt != 1) begin
      bad++;
      $display("FAIL read_done_count got %0d want 1", dcnt);
    end
    total++;
    if (gap != 2) begin
      bad++;
      $display("FAIL read_gap_len got %0d want 2", gap);
    end
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL read_word_count got %0d want 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      total++;
      if (got[k] !== w[k]) begin
        bad++;
        $display("FAIL read_word%0d got %h want %h", k, got[k], w[k]);
      end
    end
    total++;
    if (lastpos != 3) begin
      bad++;
      $display("FAIL read_last_pos got %0d want 3", lastpos);
    end
    total++;
    if (bus.hb_adr !== adr) begin
      bad++;
      $display("FAIL read_adr got %h want %h", bus.hb_adr, adr);
    end
  endtask

  task automatic test_write;
    issue(1, 1, 32'h40);
    total++;
    if ({bus.wdat_ready, bus.hb_wrq} !== 2'b10) begin
      bad++;
      $display("FAIL wfill_entry got %b want 10", {bus.wdat_ready, bus.hb_wrq});
    end
    bus.wdat_valid = 1;
    bus.wdat = 16'hA5A5;
    bus.wmask = 2'b00;
    @(negedge clk90);
    total++;
    if (bus.hb_wrq !== 1'b0) begin
      bad++;
      $display("FAIL write_wrq_early got %b want 0", bus.hb_wrq);
    end
    bus.wdat = 16'h5A5A;
    bus.wmask = 2'b10;
    @(negedge clk90);
    bus.wdat_valid = 0;
    total++;
    if ({bus.hb_wrq, bus.wdat_ready, bus.rdat_valid, bus.hb_dat_o, bus.hb_mask}
        !== {3'b100, 16'hA5A5, 3'b000}) begin
      bad++;
      $display("FAIL write_head0 got %b %h %b want 100 a5a5 000",
        {bus.hb_wrq, bus.wdat_ready, bus.rdat_valid}, bus.hb_dat_o, bus.hb_mask);
    end
    bus.hb_ready = 1;
    @(negedge clk90);
    total++;
    if ({bus.hb_wrq, bus.hb_dat_o, bus.hb_mask} !== {1'b1, 16'h5A5A, 3'b010}) begin
      bad++;
      $display("FAIL write_head1 got %b %h %b want 1 5a5a 010",
        bus.hb_wrq, bus.hb_dat_o, bus.hb_mask);
    end
    @(negedge clk90);
    bus.hb_ready = 0;
    total++;
    if ({bus.hb_wrq, bus.done} !== 2'b01) begin
      bad++;
      $display("FAIL write_end got %b want 01", {bus.hb_wrq, bus.done});
    end
  endtask

  task automatic test_reject;
    issue(0, 8, 32'h99);
    total++;
    if ({bus.err, bus.hb_rrq, bus.busy} !== 3'b100) begin
      bad++;
      $display("FAIL reject got %b want 100", {bus.err, bus.hb_rrq, bus.busy});
    end
    @(negedge clk90);
    total++;
    if ({bus.err, bus.hb_rrq, bus.busy, bus.cmd_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reject_after got %b want 0001",
        {bus.err, bus.hb_rrq, bus.busy, bus.cmd_ready});
    end
  endtask

  task automatic test_full;
    logic [15:0] exp[$];
    issue(0, 7, 32'h100);
    bus.rdat_ready = 0;
    for (int i = 0; i < 8; i++) begin
      bus.hb_valid = 1;
      bus.hb_dat_i = 16'($urandom);
      exp.push_back(bus.hb_dat_i);
      @(negedge clk90);
    end
    bus.hb_valid = 0;
    repeat (2) @(negedge clk90);
    total++;
    if ({bus.busy, bus.cmd_ready, bus.rdat_valid} !== 3'b001) begin
      bad++;
      $display("FAIL full_hold got %b want 001",
        {bus.busy, bus.cmd_ready, bus.rdat_valid});
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({bus.rdat_valid, bus.cmd_ready, bus.rdat, bus.rdat_last}
          !== {2'b10, exp[i], 1'(i == 7)}) begin
        bad++;
        $display("FAIL full_drain%0d got %b %h %b want 10 %h %b", i,
          {bus.rdat_valid, bus.cmd_ready}, bus.rdat, bus.rdat_last,
          exp[i], i == 7);
      end
      bus.rdat_ready = 1;
      @(negedge clk90);
    end
    bus.rdat_ready = 0;
    total++;
    if ({bus.cmd_ready, bus.rdat_valid} !== 2'b10) begin
      bad++;
      $display("FAIL full_empty got %b want 10", {bus.cmd_ready, bus.rdat_valid});
    end
  endtask

  task automatic test_timeout;
    int n;
    issue(0, 3, 32'h200);
    bus.rdat_ready = 0;
    for (int i = 0; i < 2; i++) begin
      bus.hb_valid = 1;
      bus.hb_dat_i = 16'($urandom);
      @(negedge clk90);
    end
    bus.hb_valid = 0;
    n = 0;
    while (!bus.err && n < 200) begin
      @(negedge clk90);
      n++;
    end
    total++;
    if (n != 64) begin
      bad++;
      $display("FAIL timeout_cycles got %0d want 64", n);
    end
    total++;
    if ({bus.rdat_valid, bus.hb_rrq, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL timeout_flush got %b want 000",
        {bus.rdat_valid, bus.hb_rrq, bus.done});
    end
    repeat (2) @(negedge clk90);
    total++;
    if ({bus.busy, bus.cmd_ready} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_idle got %b want 01", {bus.busy, bus.cmd_ready});
    end
  endtask

  task automatic test_reset_mid_write;
    issue(1, 2, 32'h300);
    for (int i = 0; i < 3; i++) begin
      bus.wdat_valid = 1;
      bus.wdat = 16'($urandom);
      bus.wmask = 2'($urandom);
      @(negedge clk90);
    end
    bus.wdat_valid = 0;
    total++;
    if (bus.hb_wrq !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_wrq_pre got %b want 1", bus.hb_wrq);
    end
    #2 rst = 1;
    #1;
    total++;
    if ({bus.hb_wrq, bus.cmd_ready, bus.busy} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_async got %b want 000",
        {bus.hb_wrq, bus.cmd_ready, bus.busy});
    end
    @(negedge clk90);
    rst = 0;
    @(negedge clk90);
    total++;
    if ({bus.cmd_ready, bus.hb_wrq, bus.rdat_valid, bus.busy} !== 4'b1000) begin
      bad++;
      $display("FAIL rstmid_release got %b want 1000",
        {bus.cmd_ready, bus.hb_wrq, bus.rdat_valid, bus.busy});
    end
  endtask

  task automatic rand_read(input int len);
    logic [15:0] exp[$];
    logic [15:0] got[$];
    logic        lst[$];
    int pushed, n, dcnt;
    pushed = 0; n = 0; dcnt = 0;
    issue(0, len, $urandom);
    while (n < 600 && (pushed <= len || got.size() < len + 1)) begin
      if (bus.done) dcnt++;
      bus.rdat_ready = 1'($urandom_range(0, 1));
      if (bus.rdat_valid && bus.rdat_ready) begin
        got.push_back(bus.rdat);
        lst.push_back(bus.rdat_last);
      end
      bus.hb_valid = pushed <= len && $urandom_range(0, 2) != 0;
      bus.hb_dat_i = 16'($urandom);
      if (bus.hb_valid) begin
        exp.push_back(bus.hb_dat_i);
        pushed++;
      end
      @(negedge clk90);
      n++;
    end
    if (bus.done) dcnt++;
    bus.hb_valid = 0;
    bus.rdat_ready = 0;
    total++;
    if (got.size() != len + 1 || dcnt != 1) begin
      bad++;
      $display("FAIL rand_read_len got %0d/%0d want %0d/1",
        got.size(), dcnt, len + 1);
    end
    for (int k = 0; k < got.size() && k <= len; k++) begin
      total++;
      if ({got[k], lst[k]} !== {exp[k], 1'(k == len)}) begin
        bad++;
        $display("FAIL rand_read_word%0d got %h/%b want %h/%b",
          k, got[k], lst[k], exp[k], k == len);
      end
    end
  endtask

  task automatic rand_write(input int len);
    logic [17:0] exp[$];
    logic [17:0] got[$];
    int idx, n, dcnt;
    idx = 0; n = 0; dcnt = 0;
    for (int i = 0; i <= len; i++) exp.push_back(18'($urandom));
    issue(1, len, $urandom);
    while (idx <= len && n < 300) begin
      bus.wdat_valid = 1'($urandom_range(0, 1));
      {bus.wmask, bus.wdat} = exp[idx];
      @(negedge clk90);
      if (bus.wdat_valid) idx++;
      n++;
    end
    bus.wdat_valid = 0;
    total++;
    if ({bus.hb_wrq, bus.wdat_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rand_write_arm got %b want 10", {bus.hb_wrq, bus.wdat_ready});
    end
    n = 0;
    while (got.size() <= len && n < 300) begin
      if (bus.done) dcnt++;
      bus.hb_ready = 1'($urandom_range(0, 1));
      if (bus.hb_ready && bus.hb_wrq)
        got.push_back({bus.hb_mask[1:0], bus.hb_dat_o});
      @(negedge clk90);
      n++;
    end
    if (bus.done) dcnt++;
    bus.hb_ready = 0;
    total++;
    if (got.size() != len + 1 || dcnt != 1 || bus.hb_wrq !== 1'b0) begin
      bad++;
      $display("FAIL rand_write_len got %0d/%0d/%b want %0d/1/0",
        got.size(), dcnt, bus.hb_wrq, len + 1);
    end
    for (int k = 0; k < got.size() && k <= len; k++) begin
      total++;
      if (got[k] !== exp[k]) begin
        bad++;
        $display("FAIL rand_write_word%0d got %h want %h", k, got[k], exp[k]);
      end
    end
  endtask

  task automatic test_random;
    int r;
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) test_reject();
      else if (r < 5) rand_read($urandom_range(0, 7));
      else rand_write($urandom_range(0, 7));
    end
  endtask

  task automatic test_back_to_back;
    rand_write(7);
    rand_read(0);
    rand_read(7);
    rand_write(0);
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_read();
    test_write();
    test_reject();
    test_full();
    test_timeout();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
